fifo_rr_push_arbiter: RTL and testbench
=======================================

Name: fifo_rr_push_arbiter

Overview:
Round-robin arbiter that shares the push port of one circular-pointer FIFO among NREQ requesters. A requester is granted ownership for a bounded burst. Words are forwarded to the FIFO only while it is not full. The block tracks FIFO occupancy from push/pop so upstream logic and the scoreboard can check push legality without probing the FIFO.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, data word width; matches the FIFO WIDTH
DEPTH, 8, FIFO depth; matches the FIFO DEPTH
MAX_BURST, 4, maximum pushes per ownership tenure (>=1)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
req  in  NREQ  per-requester push request; requester holds it until granted
req_data  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
gnt  out  NREQ  one-hot; gnt[i]=1 means req_data[i] is accepted this cycle
owner_id  out  clog2(NREQ)  current owner index; valid when busy=1
busy  out  1  1 in OWN state
fifo_push  out  1  push strobe to FIFO
fifo_data  out  WIDTH  data to FIFO; equals req_data of owner
fifo_pop  in  1  pop strobe observed at FIFO
fifo_full  in  1  FIFO full flag
occupancy  out  clog2(DEPTH+1)  tracked FIFO entry count

Behaviour:
- States: IDLE, OWN. Registers: state, owner, last, burst_cnt (clog2(MAX_BURST) bits, saturating usage), occupancy.
- Reset (rst=1 at a clock edge) forces state=IDLE, owner=0, last=NREQ-1, burst_cnt=0, occupancy=0. Outputs are combinational from these registers, so after reset gnt=0, fifo_push=0, busy=0, owner_id=0, fifo_data=req_data[0 slice]. Reset mid-burst abandons the burst; there is no partial push in the reset cycle.
- IDLE: if any req is set, select the first i with req[i] set, searching (last+1) mod NREQ, (last+2) mod NREQ, ..., wrapping. Next state is OWN with owner=i, burst_cnt=0. There are no grants in IDLE, so acquisition costs 1 cycle.
- OWN: fifo_push = req[owner] & !fifo_full. gnt = onehot(owner) & fifo_push. fifo_data = req_data[owner].
- On a push in OWN, burst_cnt increments.
- Leave OWN for IDLE, setting last=owner, when either:
  - a push occurs with burst_cnt==MAX_BURST-1, or
  - req[owner]==0 at the edge.
- fifo_full stalls but never ends a tenure. Owner keeps the slot while blocked.
- Requests from non-owners are ignored in OWN. A non-owner's req changes never affect gnt.
- occupancy: +1 on fifo_push & !fifo_pop, -1 on fifo_pop & !fifo_push, unchanged when both or neither. Simultaneous push and pop at full is impossible since push requires !fifo_full.
- Invariants for verification:
  - gnt is one-hot or zero.
  - fifo_push implies !fifo_full.
  - occupancy<=DEPTH.
  - occupancy==DEPTH iff fifo_full.
  - A requester holding req continuously is granted within (NREQ-1)*(MAX_BURST+1)+1 cycles of non-full FIFO.
- Width rules: occupancy sized clog2(DEPTH+1); owner arithmetic is mod NREQ with explicit wrap (no reliance on power-of-two NREQ).

Test Plan:
1. Reset, then req=4'b0001 held, FIFO empty, no pops -> cycle 1 IDLE, cycles 2-5 gnt=0001 and push data D0..D3. Cycle 6 IDLE, then requester 0 re-acquires. occupancy reaches 4 after cycle 5.
2. req=4'b1111 held, fifo_pop asserted whenever occupancy>0 -> owners rotate 0,1,2,3,0. Each tenure has exactly 4 gnts separated by 1 idle cycle. The last-served requester is never chosen next while others request.
3. Owner 2 pushing, fifo_full rises after 2 pushes for 3 cycles -> gnt=0 and fifo_push=0 for 3 cycles, busy=1, owner_id=2. Pushes resume; burst ends after 2 more pushes.
4. Owner 1 drops req after 1 push -> return to IDLE next cycle, last=1. Pending req[3] only is granted next (owner_id=3).
5. Assert rst mid-burst with owner=2, burst_cnt=2 -> next cycle busy=0, occupancy=0, gnt=0. With req=1111, first owner after reset is 0.
6. Push and pop in the same cycle at occupancy 3 -> occupancy stays 3. Pop alone at occupancy 1 -> 0. Formal check: no push while fifo_full, gnt one-hot.

Source files
------------

// File: rtl/fifo_rr_push_arbiter.sv
// Round-robin owner of a single FIFO push port with bounded bursts.
// Also keeps a push/pop occupancy count of the downstream FIFO.
module fifo_rr_push_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4,
  localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int OCW = $clog2(DEPTH + 1),
  localparam int BW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [OW-1:0]         owner_id,
  output logic                  busy,
  output logic                  fifo_push,
  output logic [WIDTH-1:0]      fifo_data,
  input  logic                  fifo_pop,
  input  logic                  fifo_full,
  output logic [OCW-1:0]        occupancy
);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_t;

  state_t          r_state;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   r_last;
  logic [BW-1:0]   r_burst;
  logic [OCW-1:0]  r_occ;

  logic            w_found;
  logic [OW-1:0]   w_pick;
  logic [NREQ-1:0] w_sel;
  logic            w_own_req;
  logic            w_last_push;

  // Search starts just after the last owner and wraps mod NREQ.
  always_comb begin : pick
    int          idx;
    logic [OW-1:0] w_i;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = 0;
    w_i     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(r_last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      w_i = OW'(idx);
      if (!w_found && req[w_i]) begin
        w_found = 1'b1;
        w_pick  = w_i;
      end
    end
  end

  always_comb begin
    fifo_data = req_data[WIDTH-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (r_owner == OW'(i)) fifo_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign w_sel       = NREQ'(1) << r_owner;
  assign w_own_req   = |(req & w_sel);
  assign busy        = (r_state == S_OWN);
  assign fifo_push   = busy && w_own_req && !fifo_full;
  assign gnt         = fifo_push ? w_sel : '0;
  assign owner_id    = r_owner;
  assign occupancy   = r_occ;
  assign w_last_push = fifo_push && (r_burst == BW'(MAX_BURST - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= OW'(NREQ - 1);
      r_burst <= '0;
      r_occ   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state <= S_OWN;
            r_owner <= w_pick;
            r_burst <= '0;
          end
        end
        S_OWN: begin
          // Full only stalls; tenure ends on burst limit or dropped req.
          if (w_last_push || !w_own_req) begin
            r_state <= S_IDLE;
            r_last  <= r_owner;
            r_burst <= '0;
          end else if (fifo_push) begin
            r_burst <= r_burst + BW'(1);
          end
        end
      endcase
      if (fifo_push && !fifo_pop) begin
        r_occ <= r_occ + OCW'(1);
      end else if (fifo_pop && !fifo_push) begin
        r_occ <= r_occ - OCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_push_arbiter.sv
// Scoreboard bench: driver predicts from a queue-based FIFO and tenure model,
// a negedge monitor compares DUT outputs and invariants.
module tb_fifo_rr_push_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int MB    = 4;
  localparam int OW    = 2;
  localparam int OCW   = 4;
  localparam int BOUND = (NREQ - 1) * (MB + 1) + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       gnt;
  logic [OW-1:0]         owner_id;
  logic                  busy;
  logic                  fifo_push;
  logic [WIDTH-1:0]      fifo_data;
  logic                  fifo_pop = 1'b0;
  logic                  fifo_full = 1'b0;
  logic [OCW-1:0]        occupancy;

  always #5 clk = ~clk;

  fifo_rr_push_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MB)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .owner_id(owner_id), .busy(busy),
    .fifo_push(fifo_push), .fifo_data(fifo_data),
    .fifo_pop(fifo_pop), .fifo_full(fifo_full),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic             push;
    logic [WIDTH-1:0] data;
    logic             busy;
    logic [OW-1:0]    own;
    logic [OCW-1:0]   occ;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%0h want=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("gnt", gnt, e.gnt);
      chk("fifo_push", fifo_push, e.push);
      chk("fifo_data", fifo_data, e.data);
      chk("busy", busy, e.busy);
      chk("owner_id", owner_id, e.own);
      chk("occupancy", occupancy, e.occ);
      chk("gnt_onehot0", $onehot0(gnt), 1);
      chk("push_while_full", fifo_push && fifo_full, 0);
      chk("occ_le_depth", occupancy <= DEPTH, 1);
      chk("occ_full_iff", (occupancy == DEPTH) == fifo_full, 1);
    end
  end

  // Behavioural model: tenure bookkeeping plus a real FIFO queue.
  bit               m_valid = 0;
  bit               m_busy  = 0;
  int               m_owner = 0;
  int               m_last  = NREQ - 1;
  int               m_n     = 0;
  logic [WIDTH-1:0] fq[$];

  bit               p_has = 0;
  bit               p_rst, p_push, p_pop, p_full;
  logic [NREQ-1:0]  p_req;
  logic [NREQ-1:0]  p_gnt = '0;
  logic [WIDTH-1:0] p_data;
  int               waitc[NREQ];
  int               maxw[NREQ];

  task automatic retire();
    if (!p_has) return;
    if (p_rst) begin
      m_busy  = 0;
      m_owner = 0;
      m_last  = NREQ - 1;
      m_n     = 0;
      fq.delete();
      foreach (waitc[i]) waitc[i] = 0;
      m_valid = 1;
      return;
    end
    if (p_pop) void'(fq.pop_front());
    if (p_push) fq.push_back(p_data);
    for (int i = 0; i < NREQ; i++) begin
      if (!p_req[i] || p_gnt[i]) waitc[i] = 0;
      else if (!p_full) waitc[i]++;
      if (waitc[i] > maxw[i]) maxw[i] = waitc[i];
    end
    if (!m_busy) begin
      for (int k = 1; k <= NREQ; k++) begin
        int c;
        c = (m_last + k) % NREQ;
        if (p_req[c]) begin
          m_owner = c;
          m_busy  = 1;
          m_n     = 0;
          break;
        end
      end
    end else begin
      if (p_push) m_n++;
      if (!p_req[m_owner] || m_n == MB) begin
        m_busy = 0;
        m_last = m_owner;
      end
    end
  endtask

  task automatic step(input logic [NREQ-1:0] r, input bit pop, input bit rs);
    exp_t e;
    @(posedge clk);
    #1;
    retire();
    rst = rs;
    req = rs ? '0 : r;
    for (int i = 0; i < NREQ; i++) req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
    fifo_full = (fq.size() == DEPTH);
    fifo_pop  = !rs && pop && (fq.size() > 0);
    e.busy = m_busy;
    e.own  = OW'(m_owner);
    e.push = m_busy && req[m_owner] && !fifo_full;
    e.gnt  = e.push ? (NREQ'(1) << m_owner) : '0;
    e.data = req_data[m_owner*WIDTH +: WIDTH];
    e.occ  = OCW'(fq.size());
    if (m_valid) sbq.push_back(e);
    p_has  = 1;
    p_rst  = rs;
    p_push = e.push;
    p_gnt  = e.gnt;
    p_data = e.data;
    p_full = fifo_full;
    p_req  = req;
    p_pop  = fifo_pop;
  endtask

  initial begin
    logic [NREQ-1:0] nr;
    int              pp;
    foreach (maxw[i]) maxw[i] = 0;
    foreach (waitc[i]) waitc[i] = 0;
    step('0, 0, 1);
    step('0, 0, 1);
    // Single requester, no pops: two tenures then stall on full.
    repeat (14) step(4'b0001, 0, 0);
    // All request, drain continuously: rotation 0,1,2,3,0.
    repeat (40) step(4'b1111, 1, 0);
    // Reset mid-traffic, then everyone requests again.
    step(4'b1111, 0, 1);
    repeat (12) step(4'b1111, 0, 0);
    // Random traffic with periodic resets and varying drain rates.
    pp = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) pp = $urandom_range(10, 90);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) nr[i] = p_gnt[i] ? ($urandom_range(0, 3) != 0) : 1'b1;
        else        nr[i] = ($urandom_range(0, 2) == 0);
      end
      step(nr, $urandom_range(0, 99) < pp, (c % 997) == 996);
    end
    step('0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", sbq.size(), 0);
    for (int i = 0; i < NREQ; i++) chk("fair_wait", maxw[i] <= BOUND, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
